// File: rtl/enigma_core_pkg.sv
// Shared constants for the Enigma core: states, notches,
// rotor/reflector wirings and small mod-26 helpers.
package enigma_core_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_ENC  = 2'd2;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;

    localparam logic [4:0] NOTCH_I   = 5'd16;
    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;

    localparam int SEL_I   = 0;
    localparam int SEL_II  = 1;
    localparam int SEL_III = 2;

    // Tables hold ASCII letters; character 0 sits in the top byte.
    localparam logic [207:0] W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] W_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] W_REF = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    function automatic logic [4:0] tab_at(
        input logic [207:0] t,
        input logic [4:0]   i
    );
        logic [7:0] b;
        int         idx;
        idx = 25 - int'(i);
        b   = t[8*idx +: 8];
        return 5'(b - CH_A);
    endfunction

    function automatic logic [4:0] fold26(input logic [4:0] v);
        return (v >= 5'd26) ? v - 5'd26 : v;
    endfunction

    function automatic logic [4:0] add26(
        input logic [4:0] a,
        input logic [4:0] b
    );
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    // Mod-32 wraparound makes a - b + 26 exact for a < b.
    function automatic logic [4:0] sub26(
        input logic [4:0] a,
        input logic [4:0] b
    );
        return (a >= b) ? a - b : a - b + 5'd26;
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= CH_A) && (c <= CH_Z);
    endfunction

endpackage

// File: rtl/enigma_rotor.sv
// One combinational rotor pass, forward or inverse:
// o = (W[(c+p) mod 26] - p) mod 26.
module enigma_rotor
    import enigma_core_pkg::*;
#(
    parameter int WIRING  = 0,
    parameter bit INVERSE = 1'b0
) (
    input  logic [4:0] c,
    input  logic [4:0] p,
    output logic [4:0] o
);

    localparam logic [207:0] TAB =
        (WIRING == SEL_I)  ? W_I  :
        (WIRING == SEL_II) ? W_II : W_III;

    logic [4:0] idx;
    logic [4:0] w;

    // Offset by position, look up (or search for inverse), undo offset.
    always_comb begin
        idx = add26(c, p);
        w   = 5'd0;
        if (!INVERSE) begin
            w = tab_at(TAB, idx);
        end else begin
            for (int j = 0; j < 26; j++) begin
                if (tab_at(TAB, 5'(j)) == idx) begin
                    w = 5'(j);
                end
            end
        end
        o = sub26(w, p);
    end

endmodule

// File: rtl/enigma_core.sv
// Three-rotor Enigma (I-II-III, reflector B, rings at A).
// One character per three cycles: IDLE -> STEP -> ENC.
module enigma_core
    import enigma_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [14:0] pos_in,
    input  logic        in_valid,
    input  logic [7:0]  char_in,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  char_out,
    output logic [14:0] pos_out
);

    logic [1:0] state;
    logic [4:0] pl;
    logic [4:0] pm;
    logic [4:0] pr;
    logic [7:0] ch;

    logic [4:0] c0;
    logic [4:0] r1;
    logic [4:0] m1;
    logic [4:0] l1;
    logic [4:0] rf;
    logic [4:0] l2;
    logic [4:0] m2;
    logic [4:0] r2;
    logic [7:0] enc;
    logic       mid_notch;
    logic       right_notch;

    assign c0 = 5'(ch - CH_A);
    assign rf = tab_at(W_REF, l1);

    enigma_rotor #(.WIRING(SEL_III), .INVERSE(1'b0))
        u_rf (.c(c0), .p(pr), .o(r1));
    enigma_rotor #(.WIRING(SEL_II), .INVERSE(1'b0))
        u_mf (.c(r1), .p(pm), .o(m1));
    enigma_rotor #(.WIRING(SEL_I), .INVERSE(1'b0))
        u_lf (.c(m1), .p(pl), .o(l1));
    enigma_rotor #(.WIRING(SEL_I), .INVERSE(1'b1))
        u_li (.c(rf), .p(pl), .o(l2));
    enigma_rotor #(.WIRING(SEL_II), .INVERSE(1'b1))
        u_mi (.c(l2), .p(pm), .o(m2));
    enigma_rotor #(.WIRING(SEL_III), .INVERSE(1'b1))
        u_ri (.c(m2), .p(pr), .o(r2));

    // Letters take the rotor path; anything else passes through.
    always_comb begin
        enc = ch;
        if (is_letter(ch)) begin
            enc = {3'b000, r2} + CH_A;
        end
    end

    assign mid_notch   = (pm == NOTCH_II);
    assign right_notch = (pr == NOTCH_III);

    assign in_ready = (state == S_IDLE) && !reset;
    assign pos_out  = {pl, pm, pr};

    // Control FSM, rotor stepping and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pl        <= 5'd0;
            pm        <= 5'd0;
            pr        <= 5'd0;
            ch        <= 8'h00;
            out_valid <= 1'b0;
            char_out  <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (load) begin
                        pl <= fold26(pos_in[14:10]);
                        pm <= fold26(pos_in[9:5]);
                        pr <= fold26(pos_in[4:0]);
                    end else if (in_valid) begin
                        ch    <= char_in;
                        state <= S_STEP;
                    end
                end
                (state == S_STEP): begin
                    if (is_letter(ch)) begin
                        if (mid_notch) begin
                            pl <= add26(pl, 5'd1);
                        end
                        if (mid_notch || right_notch) begin
                            pm <= add26(pm, 5'd1);
                        end
                        pr <= add26(pr, 5'd1);
                    end
                    state <= S_ENC;
                end
                (state == S_ENC): begin
                    char_out  <= enc;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_core.sv
// Scoreboard bench for enigma_core against a string-table
// Enigma model; monitor checks every out_valid pulse.
module tb_enigma_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [14:0] pos_in = 15'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  char_out;
    logic [14:0] pos_out;

    enigma_core dut (
        .clk(clk), .reset(reset), .load(load), .pos_in(pos_in),
        .in_valid(in_valid), .char_in(char_in),
        .in_ready(in_ready), .out_valid(out_valid),
        .char_out(char_out), .pos_out(pos_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cin;
        logic [7:0]  cout;
        logic [14:0] pos;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] got_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    string RI  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string RII = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string RIII = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    string RB  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int m_l = 0, m_m = 0, m_r = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int fwd(input string w, input int c, input int p);
        return ((w[(c + p) % 26] - 65) - p + 26) % 26;
    endfunction

    function automatic int inv(input string w, input int c, input int p);
        int t, j;
        t = (c + p) % 26;
        for (j = 0; j < 26; j++) if (w[j] - 65 == t) break;
        return (j - p + 26) % 26;
    endfunction

    function automatic logic [14:0] mpos();
        return {5'(m_l), 5'(m_m), 5'(m_r)};
    endfunction

    function automatic bit letter(input logic [7:0] c);
        return c >= 8'h41 && c <= 8'h5A;
    endfunction

    task automatic model(input logic [7:0] c, output logic [7:0] o);
        int x;
        o = c;
        if (letter(c)) begin
            if (m_m == 4) begin
                m_l = (m_l + 1) % 26;
                m_m = (m_m + 1) % 26;
            end else if (m_r == 21) begin
                m_m = (m_m + 1) % 26;
            end
            m_r = (m_r + 1) % 26;
            x = int'(c) - 65;
            x = fwd(RIII, x, m_r);
            x = fwd(RII, x, m_m);
            x = fwd(RI, x, m_l);
            x = RB[x] - 65;
            x = inv(RI, x, m_l);
            x = inv(RII, x, m_m);
            x = inv(RIII, x, m_r);
            o = 8'(x + 65);
        end
    endtask

    function automatic int fix(input logic [4:0] v);
        return (v >= 26) ? int'(v) - 26 : int'(v);
    endfunction

    // Scoreboard monitor: every out_valid must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: char_out %0h with nothing pending",
                         char_out);
            end else begin
                e = sb.pop_front();
                chk("char_out", 32'(char_out), 32'(e.cout));
                chk("pos_out", 32'(pos_out), 32'(e.pos));
                chk("latency", 32'(cyc - e.acc), 32'd3);
                if (letter(e.cin)) begin
                    checks++;
                    if (char_out == e.cin) begin
                        errors++;
                        $display("FAIL self_map: %0h maps to itself", e.cin);
                    end
                end
                got_q.push_back(char_out);
            end
        end
    end

    // Caller sits at a negedge; returns at the negedge after out_valid.
    task automatic send(input logic [7:0] c, input bit load_in_step);
        exp_t       e;
        logic [7:0] o;
        int         n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        char_in  = c;
        e.acc    = cyc;
        model(c, o);
        e.cin  = c;
        e.cout = o;
        e.pos  = mpos();
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_low_step", 32'(in_ready), 32'd0);
        if (load_in_step) begin
            load   = 1'b1;
            pos_in = 15'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        chk("ready_low_enc", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic do_load(input logic [14:0] p);
        load   = 1'b1;
        pos_in = p;
        @(negedge clk);
        load = 1'b0;
        m_l = fix(p[14:10]);
        m_m = fix(p[9:5]);
        m_r = fix(p[4:0]);
        chk("load_pos", 32'(pos_out), 32'(mpos()));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(8'(s[i]), 1'b0);
        @(negedge clk);
    endtask

    task automatic chk_got(input string name, input string s);
        chk({name, "_len"}, 32'(got_q.size()), 32'(s.len()));
        for (int i = 0; i < s.len() && i < got_q.size(); i++)
            chk(name, 32'(got_q[i]), 32'(s[i]));
        got_q.delete();
    endtask

    initial begin
        int n;
        logic [7:0] c;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_char", 32'(char_out), 32'd0);
        chk("rst_pos", 32'(pos_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        do_load(15'd0);
        send_str("AAAAA");
        chk_got("kat_enc", "BDZGO");
        chk("kat_pos", 32'(pos_out), 32'd5);

        do_load(15'd0);
        send_str("BDZGO");
        chk_got("kat_dec", "AAAAA");

        do_load({5'd0, 5'd3, 5'd20});
        send_str("XYZ");
        chk("dstep_pos", 32'(pos_out), 32'({5'd1, 5'd5, 5'd23}));
        got_q.delete();

        send_str("5 ");
        chk_got("passthru", "5 ");
        chk("passthru_pos", 32'(pos_out), 32'({5'd1, 5'd5, 5'd23}));

        load     = 1'b1;
        in_valid = 1'b1;
        char_in  = 8'h41;
        pos_in   = {5'd30, 5'd2, 5'd31};
        @(negedge clk);
        load     = 1'b0;
        in_valid = 1'b0;
        m_l = 4; m_m = 2; m_r = 5;
        chk("load_wins_ready", 32'(in_ready), 32'd1);
        chk("load_wins_pos", 32'(pos_out), 32'(mpos()));
        send(8'h51, 1'b1);
        send(8'h52, 1'b0);
        @(negedge clk);

        send(8'h4B, 1'b0);
        send(8'h4C, 1'b0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        char_in  = 8'h4D;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("enc_rst_pos", 32'(pos_out), 32'd0);
        chk("enc_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_l = 0; m_m = 0; m_r = 0;
        @(negedge clk);
        chk("enc_rst_ready_after", 32'(in_ready), 32'd1);
        chk("enc_rst_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            do_load(15'($urandom));
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(3) != 0)
                    c = 8'h41 + 8'($urandom_range(25));
                else
                    c = 8'($urandom_range(255));
                send(c, 1'b0);
            end
            @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
